// File: rtl/img_stream_rx.sv
// rtl/img_stream_rx.sv - pixel stream receiver: x/y recovery, sof/eol/eof markers, per-frame measurement
// Optional per-frame pixel checksum is built only when IMG_RX_CHECKSUM_EN is defined.
module img_stream_rx #(
  parameter int DATA_W = 8,
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              img_vsync,
  input  logic              img_hsync,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_x,
  output logic [CNT_W-1:0]  out_y,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_height,
  output logic [2:0]        err_flags,
  output logic [31:0]       frame_sum
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_DISP - 1);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
  state_t state, state_nx;

  logic              vs_d, hs_d;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [CNT_W-1:0]  s1_x, s1_y;
  logic [CNT_W-1:0]  cur_x, cur_y, last_w;
  logic              err_w, err_s;
  logic              publish;
  logic              start_frame, end_frame;
  logic [31:0]       sum;

  logic vs_rise, vs_fall, accept, line_close;
  assign vs_rise    = img_vsync & ~vs_d;
  assign vs_fall    = ~img_vsync & vs_d;
  assign accept     = img_valid & ~img_vsync & (state == ACTIVE);
  // A line ends the cycle after its last accepted pixel, whether valid fell or vsync cut it off.
  assign line_close = s1_valid & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE:   if (vs_rise) state_nx = SYNC;
      SYNC:   if (vs_fall) begin
                state_nx    = ACTIVE;
                start_frame = 1'b1;
              end
      ACTIVE: if (vs_rise) begin
                state_nx  = SYNC;
                end_frame = 1'b1;
              end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      hs_d     <= 1'b0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      vs_d     <= img_vsync;
      hs_d     <= img_hsync;
      s1_valid <= accept;
      if (accept) begin
        s1_data <= img_data;
        s1_x    <= cur_x;
        s1_y    <= cur_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x  <= '0;
      cur_y  <= '0;
      last_w <= '0;
      err_w  <= 1'b0;
      err_s  <= 1'b0;
    end else if (start_frame) begin
      cur_x  <= '0;
      cur_y  <= '0;
      last_w <= '0;
      err_w  <= 1'b0;
      err_s  <= 1'b0;
    end else begin
      if (accept) begin
        cur_x <= (cur_x == CNT_MAX) ? CNT_MAX : cur_x + 1'b1;
      end else if (line_close) begin
        cur_x  <= '0;
        cur_y  <= (cur_y == CNT_MAX) ? CNT_MAX : cur_y + 1'b1;
        last_w <= cur_x;
        if (cur_x != H_EXP) err_w <= 1'b1;
      end
      if (img_valid && img_vsync && state != IDLE) err_s <= 1'b1;
    end
  end

`ifdef IMG_RX_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sum <= '0;
    else if (start_frame) sum <= '0;
    else if (accept)      sum <= sum + 32'(img_data);
  end
`else
  assign sum = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vsync <= 1'b0;
      out_hsync <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_vsync <= vs_d;
      out_hsync <= hs_d;
      out_valid <= s1_valid;
      out_data  <= s1_data;
      out_x     <= s1_x;
      out_y     <= s1_y;
      out_sof   <= s1_valid && s1_x == '0 && s1_y == '0;
      out_eol   <= line_close;
      out_eof   <= line_close && s1_y == V_LAST;
    end
  end

  // Publishing one cycle after the closing vsync lets a vsync-truncated line settle first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      publish     <= 1'b0;
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      err_flags   <= '0;
      frame_sum   <= '0;
    end else begin
      publish    <= end_frame;
      frame_done <= publish;
      if (publish) begin
        meas_width  <= last_w;
        meas_height <= cur_y;
        err_flags   <= {err_s, cur_y != V_EXP, err_w};
        frame_sum   <= sum;
      end
    end
  end

endmodule

// File: tb/tb_img_stream_rx.sv
// tb/tb_img_stream_rx.sv - directed/random bench for img_stream_rx with a frame-level reference model
module tb_img_stream_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       img_vsync = 1'b0, img_hsync = 1'b0, img_valid = 1'b0;
  logic [7:0] img_data = '0;
  logic       out_vsync, out_hsync, out_valid, out_sof, out_eol, out_eof, frame_done;
  logic [7:0] out_data;
  logic [3:0] out_x, out_y, meas_width, meas_height;
  logic [2:0] err_flags;
  logic [31:0] frame_sum;

  img_stream_rx #(.DATA_W(8), .H_DISP(8), .V_DISP(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .img_vsync(img_vsync), .img_hsync(img_hsync), .img_valid(img_valid), .img_data(img_data),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_valid(out_valid), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_done(frame_done), .meas_width(meas_width), .meas_height(meas_height),
    .err_flags(err_flags), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] x, y;
    logic       sof, eol, eof;
  } pix_t;
  typedef struct {
    logic [3:0]  w, h;
    logic [2:0]  err;
    logic [31:0] sum;
    bit          tight;
  } frm_t;

  pix_t exp_pix[$];
  frm_t exp_frm[$];
  int   lens[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, last_eol = -10;

  bit          armed = 0, in_frame = 0, errw = 0, errs = 0;
  int          lines = 0, lastw = 0;
  logic [31:0] msum = 0;

  function automatic logic [3:0] sat(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  task automatic step(input logic v, input logic h, input logic val, input logic [7:0] d);
    img_vsync = v; img_hsync = h; img_valid = val; img_data = d;
    @(posedge clk); #1;
  endtask

  task automatic model_rise(input bit tight);
    frm_t f;
    if (in_frame) begin
      f.w = sat(lastw);
      f.h = sat(lines);
      f.err = {errs, lines != 4, errw};
`ifdef IMG_RX_CHECKSUM_EN
      f.sum = msum;
`else
      f.sum = 32'd0;
`endif
      f.tight = tight;
      exp_frm.push_back(f);
    end
    in_frame = 0;
    armed = 1;
  endtask

  task automatic model_fall();
    if (armed) begin
      in_frame = 1; lines = 0; lastw = 0; errw = 0; errs = 0; msum = 0;
    end
  endtask

  task automatic vblank(input int n);
    model_rise(0);
    repeat (n) step(1, 0, 0, 0);
    model_fall();
    repeat (2) step(0, 0, 0, 0);
  endtask

  task automatic send_line(input int len, input bit ramp, input int cut);
    int ly;
    logic [7:0] d;
    pix_t p;
    ly = lines;
    step(0, 1, 0, 0);
    for (int i = 0; i < len; i++) begin
      d = ramp ? 8'(i + 8 * ly) : 8'($urandom);
      if (in_frame) begin
        p.d = d; p.x = sat(i); p.y = sat(ly);
        p.sof = (i == 0 && ly == 0);
        p.eol = (i == len - 1);
        p.eof = (i == len - 1) && sat(ly) == 4'd3;
        exp_pix.push_back(p);
        msum += 32'(d);
      end
      step(0, 0, 1, d);
    end
    if (in_frame) begin
      lines++; lastw = len;
      if (len != 8) errw = 1;
    end
    if (cut > 0) begin
      errs = 1;
      model_rise(1);
      repeat (cut) step(1, 0, 1, 8'($urandom));
      repeat (3) step(1, 0, 0, 0);
      model_fall();
      step(0, 0, 0, 0);
    end else begin
      repeat (2) step(0, 0, 0, 0);
    end
  endtask

  task automatic run_frame(input bit ramp, input int cut);
    for (int i = 0; i < lens.size(); i++)
      send_line(lens[i], ramp, (i == lens.size() - 1) ? cut : 0);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    assert ({out_valid, out_sof, out_eol, out_eof, frame_done, out_vsync, out_hsync} === 7'd0)
      else begin failures++; $error("FAIL %s_flags observed=%b expected=0", tag,
        {out_valid, out_sof, out_eol, out_eof, frame_done, out_vsync, out_hsync}); end
    checks++;
    assert ({out_data, out_x, out_y, meas_width, meas_height, err_flags} === 31'd0)
      else begin failures++; $error("FAIL %s_values observed=%h expected=0", tag,
        {out_data, out_x, out_y, meas_width, meas_height, err_flags}); end
    checks++;
    assert (frame_sum === 32'd0)
      else begin failures++; $error("FAIL %s_sum observed=%0d expected=0", tag, frame_sum); end
  endtask

  always @(negedge clk) begin
    pix_t e;
    frm_t f;
    if (rst_n) begin
      cyc++;
      if (out_valid) begin
        checks++;
        assert (exp_pix.size() > 0)
          else begin failures++; $error("FAIL pix_unexpected observed=x%0d,y%0d expected=none", out_x, out_y); end
        if (exp_pix.size() > 0) begin
          e = exp_pix.pop_front();
          checks++;
          assert ({out_data, out_x, out_y, out_sof, out_eol, out_eof} === {e.d, e.x, e.y, e.sof, e.eol, e.eof})
            else begin failures++; $error("FAIL pixel observed=d%h x%0d y%0d s%b l%b f%b expected=d%h x%0d y%0d s%b l%b f%b",
              out_data, out_x, out_y, out_sof, out_eol, out_eof, e.d, e.x, e.y, e.sof, e.eol, e.eof); end
        end
      end
      if (frame_done) begin
        checks++;
        assert (exp_frm.size() > 0)
          else begin failures++; $error("FAIL frame_unexpected observed=w%0d h%0d expected=none", meas_width, meas_height); end
        if (exp_frm.size() > 0) begin
          f = exp_frm.pop_front();
          checks++;
          assert ({meas_width, meas_height, err_flags, frame_sum} === {f.w, f.h, f.err, f.sum})
            else begin failures++; $error("FAIL frame observed=w%0d h%0d e%b s%0d expected=w%0d h%0d e%b s%0d",
              meas_width, meas_height, err_flags, frame_sum, f.w, f.h, f.err, f.sum); end
          if (f.tight) begin
            checks++;
            assert (cyc === last_eol + 1)
              else begin failures++; $error("FAIL done_latency observed=%0d expected=%0d", cyc, last_eol + 1); end
          end
        end
      end
      if (out_eol) last_eol = cyc;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    send_line(8, 0, 0);
    vblank(3);
    lens = '{8, 8, 8, 8};
    run_frame(1, 0);
    vblank(3);

    lens = '{8, 8, 7, 8};
    run_frame(0, 0);
    vblank(2);
    lens = '{8, 8, 8, 8};
    run_frame(0, 0);
    vblank(2);

    lens = '{8, 8, 8, 8, 8};
    run_frame(0, 0);
    vblank(2);

    lens = '{8, 8, 5};
    run_frame(0, 2);
    lens = '{8, 8, 8, 8};
    run_frame(1, 0);
    vblank(2);

    lens = '{18, 8, 8, 8};
    run_frame(0, 0);
    vblank(2);
    lens = '{};
    for (int i = 0; i < 17; i++) lens.push_back(2);
    run_frame(0, 0);
    vblank(2);

    for (int k = 0; k < 3; k++) begin
      lens = '{};
      for (int i = 0; i < int'($urandom_range(3, 5)); i++) lens.push_back(int'($urandom_range(6, 9)));
      run_frame(0, 0);
      vblank(int'($urandom_range(1, 4)));
    end

    send_line(8, 0, 0);
    step(0, 0, 1, 8'h55);
    step(0, 0, 1, 8'h66);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    armed = 0; in_frame = 0;
    exp_pix.delete();
    exp_frm.delete();
    @(negedge clk) rst_n = 1'b1;
    send_line(8, 0, 0);
    vblank(3);
    lens = '{8, 8, 8, 8};
    run_frame(1, 0);
    vblank(3);
    repeat (6) step(0, 0, 0, 0);

    checks++;
    assert (exp_pix.size() === 0)
      else begin failures++; $error("FAIL pix_missing observed=%0d expected=0", exp_pix.size()); end
    checks++;
    assert (exp_frm.size() === 0)
      else begin failures++; $error("FAIL frame_missing observed=%0d expected=0", exp_frm.size()); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
